// File: rtl/rv32ic_pkg.sv
// rv32ic_pkg: shared constants and helpers for the rv32ic mini core.
//   - RV32I opcode / funct3 / funct7 values for the supported subset
//   - RVC quadrant and funct3 values for the supported compressed ops
//   - ALU operation enum, instruction-class enum, ALU helper and
//     RV32I encoders used by the RVC expander
package rv32ic_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C0_LW     = 3'b010;
  localparam logic [2:0] C0_SW     = 3'b110;
  localparam logic [2:0] C1_ADDI   = 3'b000;
  localparam logic [2:0] C1_LI     = 3'b010;
  localparam logic [2:0] C1_ARITH  = 3'b100;
  localparam logic [2:0] C1_BEQZ   = 3'b110;
  localparam logic [2:0] C1_BNEZ   = 3'b111;
  localparam logic [2:0] C2_MV_ADD = 3'b100;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_e;

  typedef enum logic [2:0] {
    K_ALU_R,
    K_ALU_I,
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_BAD
  } instr_kind_e;

  function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

endpackage

// File: rtl/rv32ic_mini_core_rvc_expander.sv
// rvc_expander: maps a 16-bit RVC instruction onto its RV32I equivalent.
//   c_instr  in  16  compressed instruction (bits[1:0] != 2'b11)
//   instr    out 32  expanded RV32I instruction (0 when illegal)
//   illegal  out 1   encoding is outside the supported compressed subset
module rvc_expander
  import rv32ic_pkg::*;
(
  input  logic [15:0] c_instr,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [2:0]  f3;
  logic [4:0]  rd_full;
  logic [4:0]  rs2_full;
  logic [4:0]  rs1p;
  logic [4:0]  rs2p;
  logic [11:0] imm6_sx;
  logic [11:0] uimm_w;
  logic [12:0] br_off;

  assign f3       = c_instr[15:13];
  assign rd_full  = c_instr[11:7];
  assign rs2_full = c_instr[6:2];
  // Primed register fields only reach x8..x15.
  assign rs1p     = {2'b01, c_instr[9:7]};
  assign rs2p     = {2'b01, c_instr[4:2]};
  assign imm6_sx  = {{6{c_instr[12]}}, c_instr[12], c_instr[6:2]};
  assign uimm_w   = {5'b0, c_instr[5], c_instr[12:10], c_instr[6], 2'b00};
  assign br_off   = {{4{c_instr[12]}}, c_instr[12], c_instr[6:5], c_instr[2],
                     c_instr[11:10], c_instr[4:3], 1'b0};

  always_comb begin
    instr   = '0;
    illegal = 1'b1;
    case (c_instr[1:0])
      RVC_Q0: begin
        // The all-zero halfword lands here with funct3=000 and stays illegal.
        if (f3 == C0_LW) begin
          instr   = enc_i(uimm_w, rs1p, F3_LW, rs2p, OPC_LOAD);
          illegal = 1'b0;
        end else if (f3 == C0_SW) begin
          instr   = enc_s(uimm_w, rs2p, rs1p, F3_SW);
          illegal = 1'b0;
        end
      end
      RVC_Q1: begin
        case (f3)
          C1_ADDI: begin
            instr   = enc_i(imm6_sx, rd_full, F3_ADD_SUB, rd_full, OPC_OP_IMM);
            illegal = 1'b0;
          end
          C1_LI: begin
            instr   = enc_i(imm6_sx, 5'd0, F3_ADD_SUB, rd_full, OPC_OP_IMM);
            illegal = 1'b0;
          end
          C1_ARITH: begin
            if (c_instr[12:10] == 3'b011) begin
              illegal = 1'b0;
              case (c_instr[6:5])
                2'b00:   instr = enc_r(F7_SUB,  rs2p, rs1p, F3_ADD_SUB, rs1p);
                2'b01:   instr = enc_r(F7_BASE, rs2p, rs1p, F3_XOR, rs1p);
                2'b10:   instr = enc_r(F7_BASE, rs2p, rs1p, F3_OR, rs1p);
                default: instr = enc_r(F7_BASE, rs2p, rs1p, F3_AND, rs1p);
              endcase
            end
          end
          C1_BEQZ: begin
            instr   = enc_b(br_off, 5'd0, rs1p, F3_BEQ);
            illegal = 1'b0;
          end
          C1_BNEZ: begin
            instr   = enc_b(br_off, 5'd0, rs1p, F3_BNE);
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      RVC_Q2: begin
        // rs2=0 forms are C.JR / C.JALR / C.EBREAK, none supported.
        if (f3 == C2_MV_ADD && rs2_full != 5'd0) begin
          illegal = 1'b0;
          if (c_instr[12]) instr = enc_r(F7_BASE, rs2_full, rd_full, F3_ADD_SUB, rd_full);
          else             instr = enc_r(F7_BASE, rs2_full, 5'd0, F3_ADD_SUB, rd_full);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32ic_mini_core.sv
// rv32ic_mini_core: single-cycle RV32I+C subset core with on-chip memories.
//   clk         in  1   clock, all state on rising edge
//   rst_n       in  1   asynchronous reset, active HIGH despite the name
//   imem_we     in  1   instruction-memory write strobe
//   imem_addr   in  32  instruction-memory word index
//   imem_wdata  in  32  instruction word
//   dbg_raddr   in  5   register debug read address
//   dbg_rdata   out 32  x[dbg_raddr], x0 reads 0
//   pc          out 32  address of the executing instruction
//   illegal     out 1   sticky; core frozen once set
module rv32ic_mini_core
  import rv32ic_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_we,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [31:0] pc,
  output logic        illegal
);

  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] rf_q   [32];
  logic [31:0] rf_d   [32];
  logic [31:0] pc_q, pc_d;
  logic        illegal_q, illegal_d;

  // Fetch. Reads are combinational, so a same-cycle imem write is not seen.
  logic [IAW-1:0] widx, widx_nxt;
  logic [31:0]    lo_word;
  logic [15:0]    hi_half;
  logic [15:0]    half;
  logic [31:0]    raw32;
  logic           is_rvc, in_lo, in_hi, fetch_bad;

  assign widx     = pc_q[IAW+1:2];
  assign widx_nxt = widx + IAW'(1);
  assign in_lo    = {2'b00, pc_q[31:2]} < 32'(IMEM_WORDS);
  assign in_hi    = ({2'b00, pc_q[31:2]} + 32'd1) < 32'(IMEM_WORDS);
  assign lo_word  = imem_q[widx];
  assign hi_half  = imem_q[widx_nxt][15:0];
  assign half     = pc_q[1] ? lo_word[31:16] : lo_word[15:0];
  assign is_rvc   = half[1:0] != 2'b11;
  // A 32-bit op at pc[1]=1 straddles two words.
  assign raw32    = pc_q[1] ? {hi_half, lo_word[31:16]} : lo_word;
  assign fetch_bad = !in_lo || (!is_rvc && pc_q[1] && !in_hi);

  logic [31:0] exp_instr;
  logic        exp_illegal;

  rvc_expander u_rvc_expander (
    .c_instr (half),
    .instr   (exp_instr),
    .illegal (exp_illegal)
  );

  // Decode
  logic [31:0] instr;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b;
  instr_kind_e kind;
  alu_op_e     alu_op;

  assign instr  = is_rvc ? exp_instr : raw32;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    kind   = K_BAD;
    alu_op = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          kind = K_ALU_R;
          case (f3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_AND:     alu_op = ALU_AND;
            F3_OR:      alu_op = ALU_OR;
            F3_XOR:     alu_op = ALU_XOR;
            default:    kind   = K_BAD;
          endcase
        end else if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
          kind   = K_ALU_R;
          alu_op = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        if (f3 == F3_ADD_SUB) begin
          kind = K_ALU_I;
        end else if (f3 == F3_AND) begin
          kind   = K_ALU_I;
          alu_op = ALU_AND;
        end
      end
      OPC_LOAD:   if (f3 == F3_LW) kind = K_LOAD;
      OPC_STORE:  if (f3 == F3_SW) kind = K_STORE;
      OPC_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) kind = K_BRANCH;
      default: ;
    endcase
  end

  // Execute
  logic [31:0]    rs1_val, rs2_val, alu_res, mem_addr, load_data, pc_seq, br_target;
  logic [DAW-1:0] didx;
  logic           mem_ok, br_taken, dmem_we;

  assign rs1_val   = rf_q[rs1];
  assign rs2_val   = rf_q[rs2];
  assign alu_res   = alu_calc(alu_op, rs1_val, (kind == K_ALU_R) ? rs2_val : imm_i);
  assign mem_addr  = rs1_val + ((kind == K_STORE) ? imm_s : imm_i);
  assign mem_ok    = (mem_addr[1:0] == 2'b00) && ({2'b00, mem_addr[31:2]} < 32'(DMEM_WORDS));
  assign didx      = mem_addr[DAW+1:2];
  assign load_data = dmem_q[didx];
  assign pc_seq    = pc_q + (is_rvc ? 32'd2 : 32'd4);
  assign br_target = pc_q + imm_b;
  assign br_taken  = (f3 == F3_BEQ) ? (rs1_val == rs2_val) : (rs1_val != rs2_val);

  always_comb begin
    pc_d      = pc_q;
    illegal_d = illegal_q;
    dmem_we   = 1'b0;
    for (int i = 0; i < 32; i++) rf_d[i] = rf_q[i];
    if (!illegal_q) begin
      if (fetch_bad || (is_rvc && exp_illegal) || kind == K_BAD) begin
        illegal_d = 1'b1;
      end else begin
        case (kind)
          K_ALU_R, K_ALU_I: begin
            if (rd != 5'd0) rf_d[rd] = alu_res;
            pc_d = pc_seq;
          end
          K_LOAD: begin
            if (!mem_ok) begin
              illegal_d = 1'b1;
            end else begin
              if (rd != 5'd0) rf_d[rd] = load_data;
              pc_d = pc_seq;
            end
          end
          K_STORE: begin
            if (!mem_ok) begin
              illegal_d = 1'b1;
            end else begin
              dmem_we = 1'b1;
              pc_d    = pc_seq;
            end
          end
          K_BRANCH: begin
            if (!br_taken)          pc_d      = pc_seq;
            else if (br_target[0])  illegal_d = 1'b1;
            else                    pc_d      = br_target;
          end
          default: illegal_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Memories are deliberately not reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_addr < 32'(IMEM_WORDS))) imem_q[imem_addr[IAW-1:0]] <= imem_wdata;
  end

  // Reset blocks the store of the instruction in flight.
  always_ff @(posedge clk) begin
    if (dmem_we && !rst_n) dmem_q[didx] <= rs2_val;
  end

  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf_q[dbg_raddr];
  assign pc        = pc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32ic_mini_core.sv
module tb_rv32ic_mini_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_we = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [31:0] pc;
  logic        illegal;

  always #5 clk = ~clk;

  rv32ic_mini_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .pc         (pc),
    .illegal    (illegal)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- program buffer and assembler ----------------
  logic [15:0] prog [128];
  int plen;

  task automatic prog_clear();
    for (int i = 0; i < 128; i++) prog[i] = 16'h0000;
    plen = 0;
  endtask

  task automatic emit16(input logic [15:0] h);
    prog[plen] = h;
    plen++;
  endtask

  task automatic emit32(input logic [31:0] w);
    emit16(w[15:0]);
    emit16(w[31:16]);
  endtask

  function automatic logic [15:0] c_li(int rd, int imm);
    logic [5:0] i6 = imm[5:0];
    return {3'b010, i6[5], 5'(rd), i6[4:0], 2'b01};
  endfunction

  function automatic logic [15:0] c_addi(int rd, int imm);
    logic [5:0] i6 = imm[5:0];
    return {3'b000, i6[5], 5'(rd), i6[4:0], 2'b01};
  endfunction

  // sel: 0 SUB, 1 XOR, 2 OR, 3 AND
  function automatic logic [15:0] c_alu(int sel, int rdp, int rs2p);
    return {6'b100011, 3'(rdp - 8), 2'(sel), 3'(rs2p - 8), 2'b01};
  endfunction

  function automatic logic [15:0] c_mv(int rd, int rs2);
    return {4'b1000, 5'(rd), 5'(rs2), 2'b10};
  endfunction

  function automatic logic [15:0] c_add(int rd, int rs2);
    return {4'b1001, 5'(rd), 5'(rs2), 2'b10};
  endfunction

  function automatic logic [15:0] c_mem(bit store, int rp, int rs1p, int off);
    logic [6:0] o = off[6:0];
    return {store, 2'b10, o[5:3], 3'(rs1p - 8), o[2], o[6], 3'(rp - 8), 2'b00};
  endfunction

  function automatic logic [15:0] c_br(bit bnez, int rs1p, int off);
    logic [8:0] o = off[8:0];
    return {2'b11, bnez, o[8], o[4:3], 3'(rs1p - 8), o[7:6], o[2:1], o[5], 2'b01};
  endfunction

  // sel: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  function automatic logic [31:0] r32(int sel, int rd, int rs1, int rs2);
    logic [6:0] f7 = (sel == 1) ? 7'h20 : 7'h00;
    logic [2:0] f3 = (sel == 2) ? 3'b111 : (sel == 3) ? 3'b110 : (sel == 4) ? 3'b100 : 3'b000;
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] i32(logic [2:0] f3, logic [6:0] opc, int rd, int rs1, int imm);
    logic [11:0] i = imm[11:0];
    return {i, 5'(rs1), f3, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] sw32(int rs2, int rs1, int imm);
    logic [11:0] i = imm[11:0];
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'h23};
  endfunction

  // Holds reset while loading, then releases it on a falling edge.
  task automatic load_prog();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_addr  = i;
      imem_wdata = {prog[2*i+1], prog[2*i]};
    end
    @(negedge clk);
    imem_we = 1'b0;
    rst_n   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_reg(input int r, output logic [31:0] v);
    dbg_raddr = 5'(r);
    #1;
    v = dbg_rdata;
  endtask

  // ---------------- random-program reference model ----------------
  localparam int OP_CLI = 0, OP_CADDI = 1, OP_CMV = 2, OP_CADD = 3, OP_CALU = 4,
                 OP_R32 = 5, OP_ADDI = 6, OP_ANDI = 7, OP_SW = 8, OP_LW = 9;

  typedef struct {
    int kind;
    int rd;
    int rs1;
    int rs2;
    int imm;
  } rop_t;

  rop_t        ops [40];
  logic [31:0] mr [32];
  logic [31:0] mdm [8];
  bit          mvalid [8];

  function automatic int pick_reg(bit nonzero);
    int r;
    do begin
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(8, 15));
    end while (nonzero && r == 0);
    return r;
  endfunction

  function automatic int op_size(int kind);
    return (kind <= OP_CALU) ? 2 : 4;
  endfunction

  task automatic mset(input int rd, input logic [31:0] v);
    if (rd != 0) mr[rd] = v;
  endtask

  task automatic model_step(input rop_t o);
    case (o.kind)
      OP_CLI:   mset(o.rd, 32'(o.imm));
      OP_CADDI: mset(o.rd, mr[o.rd] + 32'(o.imm));
      OP_CMV:   mset(o.rd, mr[o.rs2]);
      OP_CADD:  mset(o.rd, mr[o.rd] + mr[o.rs2]);
      OP_CALU: begin
        case (o.imm)
          0: mset(o.rd, mr[o.rd] - mr[o.rs2]);
          1: mset(o.rd, mr[o.rd] ^ mr[o.rs2]);
          2: mset(o.rd, mr[o.rd] | mr[o.rs2]);
          default: mset(o.rd, mr[o.rd] & mr[o.rs2]);
        endcase
      end
      OP_R32: begin
        case (o.imm)
          0: mset(o.rd, mr[o.rs1] + mr[o.rs2]);
          1: mset(o.rd, mr[o.rs1] - mr[o.rs2]);
          2: mset(o.rd, mr[o.rs1] & mr[o.rs2]);
          3: mset(o.rd, mr[o.rs1] | mr[o.rs2]);
          default: mset(o.rd, mr[o.rs1] ^ mr[o.rs2]);
        endcase
      end
      OP_ADDI: mset(o.rd, mr[o.rs1] + 32'(o.imm));
      OP_ANDI: mset(o.rd, mr[o.rs1] & 32'(o.imm));
      OP_SW:   mdm[o.imm / 4] = mr[o.rs2];
      default: mset(o.rd, mdm[o.imm / 4]);
    endcase
  endtask

  task automatic gen_and_emit();
    for (int k = 0; k < 8; k++) mvalid[k] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rop_t o;
      int   slot;
      o.kind = $urandom_range(0, 9);
      o.rd = 0; o.rs1 = 0; o.rs2 = 0; o.imm = 0;
      if (o.kind == OP_LW) begin
        slot = $urandom_range(0, 7);
        if (!mvalid[slot]) o.kind = OP_SW;
      end
      case (o.kind)
        OP_CLI, OP_CADDI: begin
          o.rd = pick_reg(1); o.imm = $urandom_range(0, 63) - 32;
          emit16((o.kind == OP_CLI) ? c_li(o.rd, o.imm) : c_addi(o.rd, o.imm));
        end
        OP_CMV, OP_CADD: begin
          o.rd = pick_reg(1); o.rs2 = pick_reg(1);
          emit16((o.kind == OP_CMV) ? c_mv(o.rd, o.rs2) : c_add(o.rd, o.rs2));
        end
        OP_CALU: begin
          o.rd = $urandom_range(8, 15); o.rs2 = $urandom_range(8, 15); o.imm = $urandom_range(0, 3);
          emit16(c_alu(o.imm, o.rd, o.rs2));
        end
        OP_R32: begin
          o.rd = pick_reg(0); o.rs1 = pick_reg(0); o.rs2 = pick_reg(0); o.imm = $urandom_range(0, 4);
          emit32(r32(o.imm, o.rd, o.rs1, o.rs2));
        end
        OP_ADDI, OP_ANDI: begin
          o.rd = pick_reg(0); o.rs1 = pick_reg(0); o.imm = $urandom_range(0, 4095) - 2048;
          emit32(i32((o.kind == OP_ADDI) ? 3'b000 : 3'b111, 7'h13, o.rd, o.rs1, o.imm));
        end
        OP_SW: begin
          slot = $urandom_range(0, 7);
          mvalid[slot] = 1'b1;
          o.rs2 = pick_reg(0); o.imm = slot * 4;
          emit32(sw32(o.rs2, 0, o.imm));
        end
        default: begin
          o.rd = pick_reg(0); o.imm = slot * 4;
          emit32(i32(3'b010, 7'h03, o.rd, 0, o.imm));
        end
      endcase
      ops[i] = o;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] v;
  int          mpc;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pc", pc, 32'h0);
    check("reset_illegal", {31'b0, illegal}, 32'h0);

    // Scenario 1: all-RVC arithmetic
    prog_clear();
    emit16(c_li(8, 5)); emit16(c_li(9, 3)); emit16(c_alu(3, 8, 9));
    load_prog();
    run(3);
    rd_reg(8, v); check("s1_x8", v, 32'd1);
    check("s1_pc", pc, 32'd6);

    // Scenario 2: 32-bit arithmetic
    prog_clear();
    emit32(i32(3'b000, 7'h13, 1, 0, 7)); emit32(r32(0, 2, 1, 1));
    load_prog();
    run(2);
    rd_reg(2, v); check("s2_x2", v, 32'd14);
    check("s2_pc", pc, 32'd8);

    // Scenario 3: 32-bit op straddling a word boundary
    prog_clear();
    emit16(c_li(8, -1)); emit32(i32(3'b000, 7'h13, 9, 0, 15)); emit16(c_alu(3, 8, 9));
    load_prog();
    run(3);
    rd_reg(8, v); check("s3_x8", v, 32'd15);
    check("s3_pc", pc, 32'd8);

    // Scenario 4: compressed branches, zero filler traps on a wrong path
    prog_clear();
    emit16(c_li(8, 0)); emit16(c_br(0, 8, 6)); emit16(16'h0); emit16(16'h0);
    emit16(c_li(8, 1)); emit16(c_br(1, 8, 4)); emit16(16'h0);
    emit16(c_li(8, 0)); emit16(c_br(1, 8, 4));
    load_prog();
    run(2); check("s4_beqz_taken", pc, 32'd8);
    run(2); check("s4_bnez_taken", pc, 32'd14);
    run(2); check("s4_bnez_fall", pc, 32'd18);
    check("s4_illegal", {31'b0, illegal}, 32'h0);

    // Scenario 5: countdown loop with memory traffic
    prog_clear();
    emit16(c_li(8, 10)); emit16(c_li(11, 0)); emit16(c_mem(1, 8, 11, 0));
    emit16(c_li(9, 0)); emit16(c_li(10, 1));
    emit16(c_alu(0, 8, 10)); emit16(c_addi(9, 1)); emit16(c_br(1, 8, -4));
    emit16(c_mem(0, 12, 11, 0)); emit16(c_mem(1, 8, 11, 0));
    load_prog();
    run(3);
    check("s5_dmem_first_sw", dut.dmem_q[0], 32'd10);
    run(37);
    for (int pass = 0; pass < 2; pass++) begin
      rd_reg(9, v);  check($sformatf("s5_x9_iters_p%0d", pass), v, 32'd10);
      rd_reg(8, v);  check($sformatf("s5_x8_p%0d", pass), v, 32'd0);
      rd_reg(12, v); check($sformatf("s5_x12_clw_p%0d", pass), v, 32'd10);
      check($sformatf("s5_dmem0_p%0d", pass), dut.dmem_q[0], 32'd0);
      check($sformatf("s5_halt_pc_p%0d", pass), pc, 32'd20);
      check($sformatf("s5_illegal_p%0d", pass), {31'b0, illegal}, 32'd1);
      if (pass == 0) begin
        run(3);
        check("s6_pc_frozen", pc, 32'd20);
        rd_reg(9, v); check("s6_x9_frozen", v, 32'd10);
        @(negedge clk); rst_n = 1'b1;
        run(1);
        rd_reg(9, v); check("s5_reset_x9", v, 32'd0);
        rst_n = 1'b0;
        run(40);
      end
    end

    // Scenario 6: asynchronous reset mid-loop
    rst_n = 1'b1; run(1); rst_n = 1'b0;
    run(20);
    #2 rst_n = 1'b1;
    #1;
    check("s6_rst_pc", pc, 32'd0);
    check("s6_rst_illegal", {31'b0, illegal}, 32'h0);
    for (int r = 1; r < 32; r++) begin
      rd_reg(r, v); check($sformatf("s6_rst_x%0d", r), v, 32'h0);
    end
    check("s6_dmem_intact", dut.dmem_q[0], 32'd10);
    @(negedge clk); rst_n = 1'b0;
    run(40);
    rd_reg(9, v); check("s6_rerun_x9", v, 32'd10);
    check("s6_rerun_pc", pc, 32'd20);

    // Bad LW alignment, x0 writes discarded
    prog_clear();
    emit32(i32(3'b000, 7'h13, 0, 0, 9)); emit32(i32(3'b000, 7'h13, 1, 0, 5));
    emit32(i32(3'b010, 7'h03, 1, 0, 2));
    load_prog();
    run(4);
    rd_reg(0, v); check("x0_discard", v, 32'h0);
    rd_reg(1, v); check("lw_misalign_x1", v, 32'd5);
    check("lw_misalign_pc", pc, 32'd8);
    check("lw_misalign_illegal", {31'b0, illegal}, 32'd1);

    // SW beyond data memory
    prog_clear();
    emit32(i32(3'b000, 7'h13, 1, 0, 5)); emit32(sw32(1, 0, 1024));
    load_prog();
    run(3);
    check("sw_range_pc", pc, 32'd4);
    check("sw_range_illegal", {31'b0, illegal}, 32'd1);

    // Random mixed programs against the reference model
    for (int round = 0; round < 3; round++) begin
      prog_clear();
      gen_and_emit();
      for (int r = 0; r < 32; r++) mr[r] = '0;
      mpc = 0;
      load_prog();
      for (int i = 0; i < 40; i++) begin
        run(1);
        model_step(ops[i]);
        mpc += op_size(ops[i].kind);
        check($sformatf("rnd%0d_pc_step%0d", round, i), pc, 32'(mpc));
      end
      for (int r = 1; r < 32; r++) begin
        rd_reg(r, v); check($sformatf("rnd%0d_x%0d", round, r), v, mr[r]);
      end
      run(2);
      check($sformatf("rnd%0d_end_illegal", round), {31'b0, illegal}, 32'd1);
      check($sformatf("rnd%0d_end_pc", round), pc, 32'(mpc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32ic_mini_core.md
RV32IC_MINI_CORE -- requirements
Module: rv32ic_mini_core

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256, data memory depth in 32-bit words.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, pc value while and after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous and active-high (asserted = 1), despite the _n suffix.
REQ-006 imem_we  in  1  instruction-memory load strobe, sampled on clk.
REQ-007 imem_addr  in  32  word index for the load.
REQ-008 imem_wdata  in  32  little-endian instruction word for the load.
REQ-009 dbg_raddr  in  5  register-file debug read address.
REQ-010 dbg_rdata  out  32  combinational x[dbg_raddr]; x0 always reads 0.
REQ-011 pc  out  32  address of the instruction currently executing.
REQ-012 illegal  out  1  sticky flag set by an unsupported or out-of-range instruction.

Function
REQ-013 Single-cycle core: one instruction retires per clk while rst_n=0 and illegal=0.
REQ-014 Fetch: read the halfword at pc; bits[1:0]!=2'b11 means 16-bit RVC, else 32-bit; a 32-bit instruction at pc[1]=1 is assembled from two consecutive words.
REQ-015 Next pc: pc+2 for RVC, pc+4 for 32-bit, or the branch target when taken.
REQ-016 Supported 32-bit ops: ADD, SUB, AND, OR, XOR, ADDI, ANDI, LW, SW, BEQ, BNE.
REQ-017 Supported RVC ops: C.ADD, C.MV, C.SUB, C.AND, C.OR, C.XOR, C.ADDI, C.LI, C.LW, C.SW, C.BEQZ, C.BNEZ, C.NOP.
REQ-018 RVC expansion follows the RV32C spec; rd'/rs1'/rs2' map to x8-x15; immediates sign-extended per format.
REQ-019 Arithmetic is 32-bit two's complement, wrap-around, no overflow flag.
REQ-020 Writes to x0 are discarded.
REQ-021 Branch target = pc of the branch + sign-extended offset; targets with bit0=1 set illegal.
REQ-022 LW/SW use byte address rs1+imm; bits[1:0] must be 0 and the word index must be < DMEM_WORDS, else illegal is set.
REQ-023 LW result is written to rd in the same cycle; SW updates data memory on the clk edge.
REQ-024 Unsupported encoding, all-zero halfword, or pc beyond IMEM_WORDS*4 sets illegal; pc and state then freeze.
REQ-025 imem_we is honoured at any time; writes are ignored when imem_addr >= IMEM_WORDS.
REQ-026 imem_we writing the word being fetched in the same cycle: fetch sees the old contents.

Reset
REQ-027 While rst_n=1: pc=RESET_PC, illegal=0, all registers 0, no instruction retires.
REQ-028 Instruction and data memory contents are not cleared by reset, so a program can be reloaded and rerun.
REQ-029 Asserting reset mid-program aborts the instruction in flight with no register or memory write.

Structure
REQ-030 Package rv32ic_pkg holds opcode/funct constants, the RVC quadrant/funct3 constants and the ALU-op enum.
REQ-031 One sub-module, rvc_expander: 16-bit in, 32-bit RV32I equivalent out, plus an illegal flag.

Verification
REQ-032 Scenario 1: program of C.LI x8,5; C.LI x9,3; C.AND x8,x9 -> x8=1, pc=6 after 3 cycles.
REQ-033 Scenario 2: ADDI x1,x0,7; ADD x2,x1,x1 (32-bit) -> x2=14, pc=8.
REQ-034 Scenario 3: mixed C.LI x8,-1; ADDI x9,x0,15 at pc=2 (misaligned); C.AND x8,x9 -> x8=15, pc=8.
REQ-035 Scenario 4: C.LI x8,0; C.BEQZ x8,+6 -> taken to pc=8; then C.LI x8,1; C.BNEZ x8,+4 -> taken; a BNEZ with x8=0 falls through by +2.
REQ-036 Scenario 5: subtract loop (C.SUB decrementing x8 from 10 to 0, then C.SW to dmem[0]) -> dmem[0]=0 and x9 counts 10 iterations; then reset, rerun -> same result.
REQ-037 Scenario 6: fetch of 16'h0000, or assert reset mid-loop -> illegal=1 with pc frozen; in the reset case pc=0, x1-x31=0, memory intact.
